// File: rtl/bumper_hit_detector.sv
// Bumper / ship collision detector.
// Watches the bumper and ship drawing requests during the VGA scan. The first
// same-pixel overlap of a frame is latched, reported as a single pulse at the
// next start of frame, and then further hits are ignored for a number of frames.
// A saturating counter keeps the number of reported hits for the score logic.
module bumper_hit_detector #(
  parameter int COOLDOWN_FRAMES = 8,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    enable,
  input  logic                    drawingRequestBumper,
  input  logic                    drawingRequestShip,
  input  logic signed [10:0]      pixelX,
  input  logic signed [10:0]      pixelY,
  output logic                    bumperHit,
  output logic signed [10:0]      hitX,
  output logic signed [10:0]      hitY,
  output logic [COUNT_WIDTH-1:0]  hitCount,
  output logic                    coolingDown
);

  // Frame counter must hold COOLDOWN_FRAMES; keep at least one bit when it is 0.
  localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CD_INIT = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    SEEN     = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cd_cnt;
  logic signed [10:0]     px_p1;
  logic signed [10:0]     py_p1;
  logic                   overlap;

  // Saturating increment of the reported-hit counter.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + COUNT_WIDTH'(1);
  endfunction

  // ---- stage p0 -> p1: delay the pixel position to line up with the registered requests
  // Pixel coordinate delay register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      px_p1 <= '0;
      py_p1 <= '0;
    end else begin
      px_p1 <= pixelX;
      py_p1 <= pixelY;
    end
  end

  // ---- stage p1: requests and delayed pixel refer to the same screen position
  assign overlap = drawingRequestBumper & drawingRequestShip & enable;

  // Hit state machine: latch first overlap, report at frame start, then cool down.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= ARMED;
      cd_cnt      <= '0;
      bumperHit   <= 1'b0;
      hitX        <= '0;
      hitY        <= '0;
      hitCount    <= '0;
      coolingDown <= 1'b0;
    end else begin
      bumperHit <= 1'b0;
      if (!enable) begin
        // Game paused: drop any pending hit silently and re-arm.
        state       <= ARMED;
        cd_cnt      <= '0;
        coolingDown <= 1'b0;
      end else begin
        case (state)
          ARMED: begin
            // An overlap on the frame-start cycle belongs to the new frame.
            if (overlap) begin
              hitX  <= px_p1;
              hitY  <= py_p1;
              state <= SEEN;
            end
          end
          SEEN: begin
            // Later overlaps in the frame are ignored; the first capture holds.
            if (startOfFrame) begin
              bumperHit <= 1'b1;
              hitCount  <= sat_inc(hitCount);
              if (COOLDOWN_FRAMES > 0) begin
                cd_cnt      <= CD_INIT;
                coolingDown <= 1'b1;
                state       <= COOLDOWN;
              end else begin
                state <= ARMED;
              end
            end
          end
          COOLDOWN: begin
            // The frame start that ends the cooldown does not itself detect.
            if (startOfFrame) begin
              if (cd_cnt == CNT_ONE) begin
                cd_cnt      <= '0;
                coolingDown <= 1'b0;
                state       <= ARMED;
              end else begin
                cd_cnt <= cd_cnt - CNT_ONE;
              end
            end
          end
          default: begin
            cd_cnt      <= '0;
            coolingDown <= 1'b0;
            state       <= ARMED;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bumper_hit_detector.sv
// Bench for bumper_hit_detector: two instances (cooldown 8 and cooldown 0)
// share one directed stimulus; a frame-level model predicts every output on
// every cycle and a few hand-computed snapshots pin the model.
module tb_bumper_hit_detector;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               enable;
  logic               drawingRequestBumper;
  logic               drawingRequestShip;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;

  logic               hit8, cool8, hit0, cool0;
  logic signed [10:0] hx8, hy8, hx0, hy0;
  logic [7:0]         cnt8, cnt0;

  int checks = 0;
  int errors = 0;

  bumper_hit_detector #(.COOLDOWN_FRAMES(8), .COUNT_WIDTH(8)) dut8 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .drawingRequestBumper(drawingRequestBumper), .drawingRequestShip(drawingRequestShip),
    .pixelX(pixelX), .pixelY(pixelY), .bumperHit(hit8), .hitX(hx8), .hitY(hy8),
    .hitCount(cnt8), .coolingDown(cool8)
  );

  bumper_hit_detector #(.COOLDOWN_FRAMES(0), .COUNT_WIDTH(8)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .drawingRequestBumper(drawingRequestBumper), .drawingRequestShip(drawingRequestShip),
    .pixelX(pixelX), .pixelY(pixelY), .bumperHit(hit0), .hitX(hx0), .hitY(hy0),
    .hitCount(cnt0), .coolingDown(cool0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models cooldown 8, index 1 models cooldown 0. The model counts
  // frame starts since the last reported hit: detection is blocked while that
  // count is below the cooldown length.
  localparam int BIG = 1000000;
  int                 cdv[2] = '{8, 0};
  int                 m_since[2];
  bit                 m_pend[2];
  bit                 m_hit[2];
  int                 m_cnt[2];
  logic signed [10:0] m_x[2];
  logic signed [10:0] m_y[2];
  logic signed [10:0] prev_px, prev_py;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_since[i] = BIG; m_pend[i] = 0; m_hit[i] = 0; m_cnt[i] = 0;
      m_x[i] = '0; m_y[i] = '0;
    end
    prev_px = '0; prev_py = '0;
  end

  always @(posedge clk) begin
    bit sof, en, ov, rn, blocked;
    sof = startOfFrame; en = enable; rn = resetN;
    ov  = drawingRequestBumper & drawingRequestShip & enable;
    for (int i = 0; i < 2; i++) begin
      if (!rn) begin
        m_hit[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_since[i] = BIG;
        m_x[i] = '0; m_y[i] = '0;
      end else if (!en) begin
        m_hit[i] = 0; m_pend[i] = 0; m_since[i] = BIG;
      end else begin
        m_hit[i] = 0;
        blocked = (m_since[i] < cdv[i]);
        if (sof && m_since[i] < BIG) m_since[i]++;
        if (m_pend[i]) begin
          if (sof) begin
            m_hit[i]   = 1;
            m_cnt[i]   = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            m_pend[i]  = 0;
            m_since[i] = 0;
          end
        end else if (!blocked && ov) begin
          m_pend[i] = 1;
          m_x[i] = prev_px;
          m_y[i] = prev_py;
        end
      end
    end
    if (!rn) begin
      prev_px = '0; prev_py = '0;
    end else begin
      prev_px = pixelX; prev_py = pixelY;
    end
    #1;
    chk("hit_cd8",  int'(hit8),  int'(m_hit[0]));
    chk("x_cd8",    int'(hx8),   int'(m_x[0]));
    chk("y_cd8",    int'(hy8),   int'(m_y[0]));
    chk("cnt_cd8",  int'(cnt8),  m_cnt[0]);
    chk("cool_cd8", int'(cool8), int'(m_since[0] < cdv[0]));
    chk("hit_cd0",  int'(hit0),  int'(m_hit[1]));
    chk("x_cd0",    int'(hx0),   int'(m_x[1]));
    chk("y_cd0",    int'(hy0),   int'(m_y[1]));
    chk("cnt_cd0",  int'(cnt0),  m_cnt[1]);
    chk("cool_cd0", int'(cool0), int'(m_since[1] < cdv[1]));
  end

  // ---------------- stimulus ----------------
  int fidx = -1;
  int s_hit8[512], s_x8[512], s_y8[512], s_cnt8[512], s_cool8[512];
  int s_hit0[512], s_cnt0[512];

  // One 8-cycle frame. Pixel in cycle c is (595+5c, yb+5c); requests are one
  // cycle late, so an overlap in cycle c reports the pixel of cycle c-1.
  // Cycle 6 always carries a bumper-only request (no overlap).
  task automatic run_frame(input int ova, input int ovb, input int yb,
                           input int rst_c, input int dis_c);
    fidx++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      resetN               = (c != rst_c);
      enable               = (c < dis_c);
      startOfFrame         = (c == 0);
      pixelX               = 11'(595 + 5 * c);
      pixelY               = 11'(yb + 5 * c);
      drawingRequestShip   = (c == ova) || (c == ovb);
      drawingRequestBumper = (c == ova) || (c == ovb) || (c == 6);
      if (c == 0) begin
        @(posedge clk);
        #2;
        s_hit8[fidx] = int'(hit8);  s_x8[fidx] = int'(hx8); s_y8[fidx] = int'(hy8);
        s_cnt8[fidx] = int'(cnt8);  s_cool8[fidx] = int'(cool8);
        s_hit0[fidx] = int'(hit0);  s_cnt0[fidx] = int'(cnt0);
      end
    end
  endtask

  initial begin
    int sum8, sum0;
    resetN = 1'b0; enable = 1'b1; startOfFrame = 1'b0;
    drawingRequestBumper = 1'b0; drawingRequestShip = 1'b0;
    pixelX = '0; pixelY = '0;
    repeat (2) @(negedge clk);
    chk("rst_hit",  int'(hit8),  0);
    chk("rst_x",    int'(hx8),   0);
    chk("rst_y",    int'(hy8),   0);
    chk("rst_cnt",  int'(cnt8),  0);
    chk("rst_cool", int'(cool8), 0);

    // Frames 0..19: overlap at pixel (600,40) every frame; frame 20 quiet.
    for (int k = 0; k < 20; k++) run_frame(2, -1, 35, -1, 99);
    run_frame(-1, -1, 35, -1, 99);
    chk("f1_hit",  s_hit8[1], 1);
    chk("f1_x",    s_x8[1], 600);
    chk("f1_y",    s_y8[1], 40);
    chk("f1_cnt",  s_cnt8[1], 1);
    chk("f1_cool", s_cool8[1], 1);
    chk("f8_cool", s_cool8[8], 1);
    chk("f9_cool", s_cool8[9], 0);
    chk("f9_hit",  s_hit8[9], 0);
    chk("f10_hit", s_hit8[10], 1);
    chk("f19_hit", s_hit8[19], 1);
    sum8 = 0; sum0 = 0;
    for (int k = 1; k <= 20; k++) begin
      sum8 += s_hit8[k];
      sum0 += s_hit0[k];
    end
    chk("pulses_cd8", sum8, 3);
    chk("cnt_cd8_f20", s_cnt8[20], 3);
    chk("pulses_cd0", sum0, 20);
    chk("cnt_cd0_f20", s_cnt0[20], 20);

    // Frame 21: one-cycle reset in the middle of the cooldown.
    run_frame(-1, -1, 35, 3, 99);
    chk("midrst_cnt",  int'(cnt8), 0);
    chk("midrst_cool", int'(cool8), 0);
    chk("midrst_x",    int'(hx8), 0);

    // Frame 22: overlaps at (600,40) then (610,50); only the first is reported.
    run_frame(2, 4, 35, -1, 99);
    run_frame(-1, -1, 35, -1, 99);
    chk("dbl_hit",  s_hit8[23], 1);
    chk("dbl_x",    s_x8[23], 600);
    chk("dbl_y",    s_y8[23], 40);
    chk("dbl_cnt",  s_cnt8[23], 1);
    chk("dbl_cool", s_cool8[23], 1);

    // Frame 24: capture at (600,-55), then enable drops before frame end.
    run_frame(2, -1, -60, -1, 5);
    run_frame(-1, -1, 35, -1, 99);
    chk("dis_hit0",  s_hit0[25], 0);
    chk("dis_cnt0",  s_cnt0[25], 1);
    chk("dis_x0",    int'(hx0), 600);
    chk("dis_y0",    int'(hy0), -55);
    chk("dis_cool8", s_cool8[25], 0);
    chk("dis_cnt8",  s_cnt8[25], 1);

    // Frames 26..285: overlap every frame, sometimes also on the frame-start cycle.
    for (int k = 0; k < 260; k++) run_frame(2, (k % 3 == 0) ? 0 : -1, 35, -1, 99);
    run_frame(-1, -1, 35, -1, 99);
    chk("sat_cnt0", s_cnt0[286], 255);
    chk("sat_hit0", s_hit0[286], 1);
    chk("sat_hit0_prev", s_hit0[285], 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
